// File: rtl/subsistema_bcd_binario.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one shift per clock.
// Optional digit validation and the errorDigito port are built when ERROR_DIGITO_EN is defined.
module subsistema_bcd_binario #(
  parameter int DIGITOS   = 3,
  parameter int ANCHO_BIN = 10
) (
  input  logic                   reloj,
  input  logic                   reinicio,
  input  logic [4*DIGITOS-1:0]   bcdEntrada,
  input  logic                   banderaLista,
  output logic [ANCHO_BIN-1:0]   resultado,
  output logic                   banderaConvertida,
  output logic                   ocupado
`ifdef ERROR_DIGITO_EN
  ,
  output logic                   errorDigito
`endif
);

  localparam int ANCHO_BCD = 4 * DIGITOS;
  localparam int ANCHO_REG = ANCHO_BCD + ANCHO_BIN;
  localparam int ANCHO_CNT = $clog2(ANCHO_BIN + 1);
  localparam logic [ANCHO_CNT-1:0] ULTIMA = ANCHO_CNT'(ANCHO_BIN - 1);

  typedef enum logic [1:0] {REPOSO, DESPLAZA, FIN} estado_t;

  estado_t                 estado_reg, estado_next;
  logic [ANCHO_REG-1:0]    registro_reg, registro_next;
  logic [ANCHO_CNT-1:0]    contador_reg, contador_next;
  logic [ANCHO_BIN-1:0]    resultado_reg, resultado_next;
  logic                    convertida_reg, convertida_next;
  logic [ANCHO_REG-1:0]    desplazado;
  logic [ANCHO_REG-1:0]    corregido;

  assign desplazado = {1'b0, registro_reg[ANCHO_REG-1:1]};
  assign corregido[ANCHO_BIN-1:0] = desplazado[ANCHO_BIN-1:0];

  // Digits that reached 8 or more after the shift held a half-ten borrow; remove it.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITOS; gi++) begin : g_correccion
      localparam int LSB = ANCHO_BIN + 4 * gi;
      assign corregido[LSB +: 4] = (desplazado[LSB +: 4] >= 4'd8) ?
                                   (desplazado[LSB +: 4] - 4'd3) : desplazado[LSB +: 4];
    end
  endgenerate

`ifdef ERROR_DIGITO_EN
  logic [DIGITOS-1:0] digito_invalido;
  logic               error_reg, error_next;
  logic               error_out_reg, error_out_next;

  generate
    for (gi = 0; gi < DIGITOS; gi++) begin : g_validacion
      assign digito_invalido[gi] = (bcdEntrada[4*gi +: 4] > 4'd9);
    end
  endgenerate

  assign errorDigito = error_out_reg;
`endif

  always_ff @(posedge reloj) begin
    if (reinicio) begin
      estado_reg     <= REPOSO;
      registro_reg   <= '0;
      contador_reg   <= '0;
      resultado_reg  <= '0;
      convertida_reg <= 1'b0;
`ifdef ERROR_DIGITO_EN
      error_reg      <= 1'b0;
      error_out_reg  <= 1'b0;
`endif
    end else begin
      estado_reg     <= estado_next;
      registro_reg   <= registro_next;
      contador_reg   <= contador_next;
      resultado_reg  <= resultado_next;
      convertida_reg <= convertida_next;
`ifdef ERROR_DIGITO_EN
      error_reg      <= error_next;
      error_out_reg  <= error_out_next;
`endif
    end
  end

  always_comb begin
    estado_next     = estado_reg;
    registro_next   = registro_reg;
    contador_next   = contador_reg;
    resultado_next  = resultado_reg;
    convertida_next = 1'b0;
`ifdef ERROR_DIGITO_EN
    error_next      = error_reg;
    error_out_next  = error_out_reg;
`endif
    case (estado_reg)
      REPOSO: begin
        if (banderaLista) begin
          registro_next = {bcdEntrada, {ANCHO_BIN{1'b0}}};
          contador_next = '0;
          estado_next   = DESPLAZA;
`ifdef ERROR_DIGITO_EN
          error_next    = |digito_invalido;
`endif
        end
      end
      DESPLAZA: begin
        // The last shift lands the final bit; no digit correction follows it.
        registro_next = (contador_reg == ULTIMA) ? desplazado : corregido;
        contador_next = contador_reg + 1'b1;
        if (contador_reg == ULTIMA) estado_next = FIN;
      end
      FIN: begin
        resultado_next  = registro_reg[ANCHO_BIN-1:0];
`ifdef ERROR_DIGITO_EN
        if (error_reg) resultado_next = '0;
        error_out_next  = error_reg;
`endif
        convertida_next = 1'b1;
        estado_next     = REPOSO;
      end
      default: estado_next = REPOSO;
    endcase
  end

  assign resultado         = resultado_reg;
  assign banderaConvertida = convertida_reg;
  assign ocupado           = (estado_reg != REPOSO);

endmodule

// File: tb/tb_subsistema_bcd_binario.sv
// Randomized and directed bench for subsistema_bcd_binario, checked against an arithmetic model.
module tb_subsistema_bcd_binario;

  logic        reloj = 1'b0;
  logic        reinicio = 1'b1;
  logic [11:0] bcdEntrada = '0;
  logic        banderaLista = 1'b0;
  logic [9:0]  resultado;
  logic        banderaConvertida;
  logic        ocupado;
`ifdef ERROR_DIGITO_EN
  logic        errorDigito;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  subsistema_bcd_binario #(.DIGITOS(3), .ANCHO_BIN(10)) dut (
    .reloj(reloj),
    .reinicio(reinicio),
    .bcdEntrada(bcdEntrada),
    .banderaLista(banderaLista),
    .resultado(resultado),
    .banderaConvertida(banderaConvertida),
    .ocupado(ocupado)
`ifdef ERROR_DIGITO_EN
    ,
    .errorDigito(errorDigito)
`endif
  );

  always #5 reloj = ~reloj;

  task automatic tick();
    @(posedge reloj);
    #1;
  endtask

  // Reference model: positional value of the decimal digits.
  function automatic int bcd_value(input logic [11:0] b);
    return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  // Runs one conversion and reports what was observed; the caller judges it.
  task automatic do_conv(input logic [11:0] bcd, output int lat, output logic [9:0] res,
                         output logic busy_start, output logic busy_pulse, output logic pulse_after);
    bcdEntrada   = bcd;
    banderaLista = 1'b1;
    tick();
    banderaLista = 1'b0;
    busy_start = ocupado;
    lat = -1;
    res = 'x;
    busy_pulse = 1'bx;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (banderaConvertida) begin
        lat = i;
        res = resultado;
        busy_pulse = ocupado;
        break;
      end
    end
    tick();
    pulse_after = banderaConvertida;
  endtask

  task automatic test_reset();
    reinicio = 1'b1;
    tick();
    tick();
    reinicio = 1'b0;
    tests_run++;
    if (resultado !== 10'd0) begin tests_failed++; $display("FAIL reset_resultado got=%0d exp=0", resultado); end
    tests_run++;
    if (banderaConvertida !== 1'b0) begin tests_failed++; $display("FAIL reset_bandera got=%b exp=0", banderaConvertida); end
    tests_run++;
    if (ocupado !== 1'b0) begin tests_failed++; $display("FAIL reset_ocupado got=%b exp=0", ocupado); end
`ifdef ERROR_DIGITO_EN
    tests_run++;
    if (errorDigito !== 1'b0) begin tests_failed++; $display("FAIL reset_error got=%b exp=0", errorDigito); end
`endif
  endtask

  task automatic test_directed();
    logic [11:0] vec [4] = '{12'h999, 12'h000, 12'h255, 12'h100};
    int lat;
    logic [9:0] res;
    logic bs, bp, pa;
    for (int v = 0; v < 4; v++) begin
      do_conv(vec[v], lat, res, bs, bp, pa);
      $display("[TB] directed bcd=%h res=%0d lat=%0d", vec[v], res, lat);
      tests_run++;
      if (lat !== 11) begin tests_failed++; $display("FAIL directed_latency bcd=%h got=%0d exp=11", vec[v], lat); end
      tests_run++;
      if (res !== 10'(bcd_value(vec[v]))) begin tests_failed++; $display("FAIL directed_result bcd=%h got=%0d exp=%0d", vec[v], res, bcd_value(vec[v])); end
      tests_run++;
      if (bs !== 1'b1) begin tests_failed++; $display("FAIL directed_busy_start bcd=%h got=%b exp=1", vec[v], bs); end
      tests_run++;
      if (bp !== 1'b0) begin tests_failed++; $display("FAIL directed_busy_at_pulse bcd=%h got=%b exp=0", vec[v], bp); end
      tests_run++;
      if (pa !== 1'b0) begin tests_failed++; $display("FAIL directed_pulse_width bcd=%h got=%b exp=0", vec[v], pa); end
    end
  endtask

  task automatic test_random();
    int lat;
    logic [9:0] res;
    logic bs, bp, pa;
    logic [11:0] bcd;
    for (int n = 0; n < 25; n++) begin
      for (int d = 0; d < 3; d++) bcd[4*d +: 4] = 4'($urandom_range(0, 9));
      do_conv(bcd, lat, res, bs, bp, pa);
      $display("[TB] random bcd=%h res=%0d lat=%0d", bcd, res, lat);
      tests_run++;
      if (lat !== 11 || res !== 10'(bcd_value(bcd))) begin
        tests_failed++;
        $display("FAIL random_conv bcd=%h got=%0d/lat%0d exp=%0d/lat11", bcd, res, lat, bcd_value(bcd));
      end
    end
  endtask

  task automatic test_ignore_busy();
    int pulses = 0;
    int first = -1;
    bcdEntrada   = 12'h123;
    banderaLista = 1'b1;
    tick();
    banderaLista = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      if (i == 3 || i == 10 || i == 11) begin
        bcdEntrada   = 12'h456;
        banderaLista = (i != 11);
      end
      tick();
      banderaLista = 1'b0;
      if (banderaConvertida) begin
        pulses++;
        if (first < 0) first = i;
        tests_run++;
        if (resultado !== 10'd123) begin tests_failed++; $display("FAIL ignore_result got=%0d exp=123", resultado); end
      end
    end
    $display("[TB] ignore_busy pulses=%0d first=%0d res=%0d", pulses, first, resultado);
    tests_run++;
    if (pulses !== 1 || first !== 11) begin tests_failed++; $display("FAIL ignore_pulses got=%0d@%0d exp=1@11", pulses, first); end
    tests_run++;
    if (resultado !== 10'd123 || ocupado !== 1'b0) begin tests_failed++; $display("FAIL ignore_hold got=%0d/%b exp=123/0", resultado, ocupado); end
  endtask

  task automatic test_abort();
    int pulses = 0;
    int lat;
    logic [9:0] res;
    logic bs, bp, pa;
    bcdEntrada   = 12'h789;
    banderaLista = 1'b1;
    tick();
    banderaLista = 1'b0;
    for (int i = 1; i < 5; i++) tick();
    reinicio = 1'b1;
    tick();
    reinicio = 1'b0;
    tests_run++;
    if (resultado !== 10'd0 || banderaConvertida !== 1'b0 || ocupado !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_outputs got=%0d/%b/%b exp=0/0/0", resultado, banderaConvertida, ocupado);
    end
    for (int i = 0; i < 15; i++) begin
      tick();
      if (banderaConvertida) pulses++;
    end
    tests_run++;
    if (pulses !== 0) begin tests_failed++; $display("FAIL abort_no_pulse got=%0d exp=0", pulses); end
    do_conv(12'h042, lat, res, bs, bp, pa);
    $display("[TB] abort_then_042 res=%0d lat=%0d", res, lat);
    tests_run++;
    if (lat !== 11 || res !== 10'd42) begin tests_failed++; $display("FAIL abort_restart got=%0d/lat%0d exp=42/lat11", res, lat); end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int last = -1;
    bcdEntrada   = 12'h500;
    banderaLista = 1'b1;
    tick();
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (banderaConvertida) begin
        pulses++;
        $display("[TB] back_to_back pulse at %0d res=%0d", i, resultado);
        tests_run++;
        if ((last < 0 && i !== 11) || (last >= 0 && i - last !== 12) || resultado !== 10'd500) begin
          tests_failed++;
          $display("FAIL b2b_pulse at=%0d prev=%0d res=%0d exp_spacing=12 exp_res=500", i, last, resultado);
        end
        last = i;
      end
    end
    banderaLista = 1'b0;
    tests_run++;
    if (pulses !== 3) begin tests_failed++; $display("FAIL b2b_count got=%0d exp=3", pulses); end
    for (int i = 0; i < 15; i++) tick();
  endtask

  task automatic test_invalid_digit();
    int lat;
    logic [9:0] res;
    logic bs, bp, pa;
    do_conv(12'h1A3, lat, res, bs, bp, pa);
    $display("[TB] invalid bcd=1a3 res=%0d lat=%0d", res, lat);
    tests_run++;
    if (lat !== 11) begin tests_failed++; $display("FAIL invalid_latency got=%0d exp=11", lat); end
`ifdef ERROR_DIGITO_EN
    tests_run++;
    if (res !== 10'd0 || errorDigito !== 1'b1) begin tests_failed++; $display("FAIL invalid_error got=%0d/%b exp=0/1", res, errorDigito); end
    do_conv(12'h321, lat, res, bs, bp, pa);
    $display("[TB] valid_after_invalid res=%0d lat=%0d err=%b", res, lat, errorDigito);
    tests_run++;
    if (res !== 10'd321 || errorDigito !== 1'b0 || lat !== 11) begin
      tests_failed++;
      $display("FAIL invalid_recover got=%0d/%b/lat%0d exp=321/0/lat11", res, errorDigito, lat);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_busy();
    test_abort();
    test_back_to_back();
    test_invalid_digit();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/subsistema_bcd_binario.md
Name: subsistema_bcd_binario

Overview:
- Sequential BCD-to-binary converter. It is the inverse of the binary-to-BCD conversion subsystem.
- Accepts a packed BCD word from the display/keypad side on a `banderaLista` start strobe.
- Converts it with a reverse double-dabble algorithm: one shift-right and digit correction per clock.
- Returns the binary value with a one-cycle `banderaConvertida` pulse. Feeds the arithmetic datapath.

Parameters:
- DIGITOS, 3, number of BCD digits in the input word (input width = 4*DIGITOS).
- ANCHO_BIN, 10, output binary width. Must be >= ceil(log2(10^DIGITOS)); 10 for 3 digits (max 999).

Ports:
- reloj  input  1  clock; all logic on rising edge.
- reinicio  input  1  synchronous reset, active-high.
- bcdEntrada  input  4*DIGITOS  packed BCD; bits [3:0] are the units digit.
- banderaLista  input  1  start strobe; sampled only when not busy.
- resultado  output  ANCHO_BIN  binary result; held until the next completion.
- banderaConvertida  output  1  one-cycle pulse: `resultado` is valid.
- ocupado  output  1  high while a conversion is in progress.
- errorDigito  output  1  present only with ERROR_DIGITO_EN; a digit was > 9.

Behaviour:
- Reset, applied on any edge with reinicio=1:
  - state=REPOSO; resultado=0; banderaConvertida=0; ocupado=0; errorDigito=0; shift register and counter cleared.
  - Overrides everything, including a conversion in progress. An aborted conversion produces no banderaConvertida pulse.
- Internal shift register: 4*DIGITOS+ANCHO_BIN bits = {bcd part, bin part}, plus a counter of ceil(log2(ANCHO_BIN+1)) bits.
- FSM states: REPOSO, DESPLAZA, FIN.
- REPOSO: ocupado=0. On an edge with banderaLista=1:
  - load {bcdEntrada, ANCHO_BIN'b0}; counter=0; go to DESPLAZA; ocupado=1 from the next cycle.
- DESPLAZA, one iteration per edge:
  - logical shift right of the whole register by 1; MSB filled with 0.
  - then, in the same cycle, each 4-bit BCD digit >= 8 is reduced by 3.
  - correction is skipped on the final iteration (counter=ANCHO_BIN-1).
  - counter increments; after ANCHO_BIN iterations go to FIN.
- FIN, one cycle:
  - resultado <= bin part; banderaConvertida=1 during the cycle after entering FIN; return to REPOSO.
  - ocupado drops to 0 in the same cycle as the pulse.
- Latency:
  - the start is accepted at edge k; banderaConvertida is high in the cycle after edge k+ANCHO_BIN+1 (11 edges for the defaults).
  - Latency is constant and independent of data.
- banderaLista while ocupado=1 (DESPLAZA or FIN): ignored, not queued.
- banderaLista=1 in the same cycle banderaConvertida is high: state is already REPOSO, so the new start is accepted. Back-to-back throughput is one conversion per ANCHO_BIN+2 cycles.
- banderaLista held high continuously: restarts immediately after each completion.
- bcdEntrada is sampled only at the accepting edge; later changes have no effect on that conversion.
- banderaConvertida is never high for more than one consecutive cycle.

Optional Feature:
- Macro: ERROR_DIGITO_EN.
- Defined:
  - in REPOSO, at the accepting edge, every digit of bcdEntrada is checked for > 9.
  - If any digit is invalid, the conversion still runs with the same latency, but at completion resultado=0 and errorDigito=1, both in the same cycle as banderaConvertida.
  - errorDigito holds until the next completion or reset, and is 0 after a valid conversion.
- Undefined:
  - the errorDigito port and checking logic are absent.
  - Invalid digits pass through the algorithm unchecked; resultado is deterministic but unspecified, and the bench must not check it.

Test Plan:
- Reset, then bcdEntrada=12'h999 with banderaLista pulsed 1 cycle -> ocupado high; banderaConvertida pulses exactly 11 edges later with resultado=10'd999 (0x3E7).
- bcdEntrada=12'h000 -> resultado=0. bcdEntrada=12'h255 -> resultado=255. bcdEntrada=12'h100 -> resultado=100. Each completes at 11-edge latency.
- Start with 12'h123; pulse banderaLista with 12'h456 at cycles 3 and 10 -> only 123 is produced, with a single pulse; resultado=123 is held afterwards.
- Start with 12'h789; assert reinicio at cycle 5 -> all outputs 0, no pulse. A new start with 12'h042 -> resultado=42 at normal latency.
- banderaLista held high with bcdEntrada=12'h500 -> pulses every 12 cycles, each with resultado=500 and no pulses in between.
- With ERROR_DIGITO_EN: bcdEntrada=12'h1A3 -> after 11 edges banderaConvertida=1, errorDigito=1, resultado=0. Next 12'h321 -> errorDigito=0, resultado=321.
